// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM status, data word and the RAM
// arbiter state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arbstate_t;

endpackage

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between icache and dcache. dcache normally wins,
// but a waiting icache is forced through after STARVE_MAX dcache words.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
);

  localparam logic [2:0] StarveLim = 3'(STARVE_MAX);

  arbstate_t  state_q, state_d;
  arbstate_t  curState;
  logic [2:0] starveCnt_q, starveCnt_d;
  logic       dReq;
  logic       iDone;
  logic       dDone;

  assign dReq  = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

  // Outputs fall back to their idle values while reset is held, even mid-grant.
  assign curState = RST ? IDLE : state_q;

  assign iDone = (curState == IGNT) && iREN && (ramstate == ACCESS);
  assign dDone = (curState == DGNT) && dReq && (ramstate == ACCESS);

  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (curState)
      IDLE: begin
        if (dReq) begin
          state_d = (!iREN || (starveCnt_q < StarveLim)) ? DGNT : IGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = (ramstate != ACCESS);
        if (!iREN || (ramstate == ACCESS) || (ramstate == ERROR)) begin
          state_d = IDLE;
        end
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = (ramstate != ACCESS);
        if (!dReq || (ramstate == ACCESS) || (ramstate == ERROR)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counts dcache words served while icache is kept waiting.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!iREN || iDone) begin
      starveCnt_d = '0;
    end else if (dDone && (starveCnt_q < StarveLim)) begin
      starveCnt_d = starveCnt_q + 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      starveCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      starveCnt_q <= starveCnt_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a simple RAM model with programmable
// latency and error injection, plus directed icache/dcache traffic.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  typedef struct {
    bit          isI;
    bit          isWr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sbQ[$];

  int assertCount = 0;
  int failCount   = 0;

  int latency = 0;
  int errArm  = 0;
  int errUsed = 0;
  int busyCnt = 0;

  logic [31:0] memW    [0:255];
  logic        written [0:255];

  logic [31:0] iAddrList [0:7];
  int          iCount;
  logic [31:0] dAddrList [0:7];
  logic [31:0] dDataList [0:7];
  int          dKindList [0:7];
  int          dCount;
  int          iLastWait;
  int          dLastWait;

  ram_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Unwritten locations read back as C0DE_<low addr>, except 0x40.
  always_comb begin
    if (written[ramaddr[7:0]] === 1'b1) ramload = memW[ramaddr[7:0]];
    else if (ramaddr == 32'h40)        ramload = 32'hDEADBEEF;
    else                               ramload = {16'hC0DE, ramaddr[15:0]};
  end

  always_comb begin
    if (!(ramREN | ramWEN))       ramstate = FREE;
    else if (errArm > errUsed)    ramstate = ERROR;
    else if (busyCnt >= latency)  ramstate = ACCESS;
    else                          ramstate = BUSY;
  end

  always @(posedge CLK) begin
    if (RST || ramstate != BUSY) busyCnt <= 0;
    else                         busyCnt <= busyCnt + 1;
    if (ramstate == ERROR) errUsed <= errUsed + 1;
    if (ramstate == ACCESS && ramWEN) begin
      memW[ramaddr[7:0]]    <= ramstore;
      written[ramaddr[7:0]] <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExp(input bit isI, input bit isWr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.isI = isI; e.isWr = isWr; e.addr = addr; e.data = data;
    sbQ.push_back(e);
  endtask

  // Monitor: every completion cycle must match the next expected word.
  always @(negedge CLK) begin
    if (!RST && (!iwait || !dwait)) begin
      exp_t e;
      checkOutput("bothWaitLow", {31'b0, iwait | dwait}, 32'd1);
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedCompletion", {30'b0, !iwait, !dwait}, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("completionPort", {31'b0, !iwait}, {31'b0, e.isI});
        checkOutput("completionAddr", ramaddr, e.addr);
        if (e.isWr) begin
          checkOutput("writeStrobes", {30'b0, ramWEN, ramREN}, 32'd2);
          checkOutput("writeData", ramstore, e.data);
        end else begin
          checkOutput("readStrobes", {30'b0, ramWEN, ramREN}, 32'd1);
          checkOutput("readData", e.isI ? iload : dload, e.data);
        end
      end
    end
  end

  task automatic waitDone(input bit isI, output int cycles);
    int cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while ((isI ? iwait : dwait) && cyc < 100);
    if (isI) checkOutput("iTimeout", {31'b0, iwait}, 32'd0);
    else     checkOutput("dTimeout", {31'b0, dwait}, 32'd0);
    cycles = cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic iDriver();
    for (int k = 0; k < iCount; k++) begin
      iREN  = 1'b1;
      iaddr = iAddrList[k];
      waitDone(1'b1, iLastWait);
    end
    iREN = 1'b0;
  endtask

  task automatic dDriver();
    for (int k = 0; k < dCount; k++) begin
      daddr  = dAddrList[k];
      dstore = dDataList[k];
      dREN   = (dKindList[k] != 1);
      dWEN   = (dKindList[k] != 0);
      waitDone(1'b0, dLastWait);
    end
    dREN = 1'b0;
    dWEN = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, "Strobes"}, {30'b0, ramREN, ramWEN}, 32'd0);
    checkOutput({name, "Addr"}, ramaddr, 32'd0);
    checkOutput({name, "Store"}, ramstore, 32'd0);
    checkOutput({name, "Waits"}, {30'b0, iwait, dwait}, 32'd3);
  endtask

  task automatic applyStimulus();
    RST = 1'b1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
    iCount = 0; dCount = 0;
    repeat (3) @(negedge CLK);
    checkIdleOutputs("reset");
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checkIdleOutputs("afterReset");
    @(posedge CLK); #1;

    // icache read with one BUSY cycle before ACCESS.
    latency = 1;
    pushExp(1, 0, 32'h40, 32'hDEADBEEF);
    iAddrList[0] = 32'h40; iCount = 1;
    iDriver();
    checkOutput("iLatency", iLastWait, 3);

    // Simultaneous dcache write and icache read: dcache first.
    latency = 0;
    pushExp(0, 1, 32'h3100, 32'h5);
    pushExp(1, 0, 32'h3100, 32'h5);
    dAddrList[0] = 32'h3100; dDataList[0] = 32'h5; dKindList[0] = 1; dCount = 1;
    iAddrList[0] = 32'h3100; iCount = 1;
    fork
      dDriver();
      iDriver();
    join
    @(posedge CLK); #1;

    // Starvation limit: four dcache words, one icache word, dcache resumes.
    dAddrList[0] = 32'h10; dAddrList[1] = 32'h14; dAddrList[2] = 32'h18;
    dAddrList[3] = 32'h1C; dAddrList[4] = 32'h30; dAddrList[5] = 32'h34;
    for (int k = 0; k < 6; k++) begin
      dKindList[k] = 0;
      dDataList[k] = 0;
    end
    dCount = 6;
    iAddrList[0] = 32'h40; iCount = 1;
    pushExp(0, 0, 32'h10, 32'hC0DE0010);
    pushExp(0, 0, 32'h14, 32'hC0DE0014);
    pushExp(0, 0, 32'h18, 32'hC0DE0018);
    pushExp(0, 0, 32'h1C, 32'hC0DE001C);
    pushExp(1, 0, 32'h40, 32'hDEADBEEF);
    pushExp(0, 0, 32'h30, 32'hC0DE0030);
    pushExp(0, 0, 32'h34, 32'hC0DE0034);
    fork
      dDriver();
      iDriver();
    join
    @(posedge CLK); #1;

    // Five BUSY cycles then ACCESS: one idle + five busy + completion sample.
    latency = 5;
    dAddrList[0] = 32'h10; dKindList[0] = 0; dCount = 1;
    pushExp(0, 0, 32'h10, 32'hC0DE0010);
    dDriver();
    checkOutput("dBusyWait", dLastWait, 7);
    @(negedge CLK);
    checkIdleOutputs("afterBusy");
    @(posedge CLK); #1;

    // ERROR once, then the held request is re-granted and completes.
    latency = 0;
    errArm = errArm + 1;
    dAddrList[0] = 32'h18; dKindList[0] = 0; dCount = 1;
    pushExp(0, 0, 32'h18, 32'hC0DE0018);
    dDriver();
    checkOutput("dErrorRetry", dLastWait, 4);

    // dcache drops its request mid-grant.
    latency = 5;
    dREN = 1'b1; daddr = 32'h1C;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("dropGranted", {31'b0, ramREN}, 32'd1);
    #1 dREN = 1'b0;
    #1 checkOutput("dropStrobe", {31'b0, ramREN}, 32'd0);
    @(negedge CLK);
    checkIdleOutputs("afterDrop");
    @(posedge CLK); #1;

    // Both dREN and dWEN: write wins, then read back through icache.
    latency = 0;
    dAddrList[0] = 32'h24; dDataList[0] = 32'h77; dKindList[0] = 2; dCount = 1;
    pushExp(0, 1, 32'h24, 32'h77);
    dDriver();
    iAddrList[0] = 32'h24; iCount = 1;
    pushExp(1, 0, 32'h24, 32'h77);
    iDriver();

    // Build starvation count of 2, then reset in the middle of a busy IGNT.
    iREN = 1'b1; iaddr = 32'h20;
    dAddrList[0] = 32'h10; dAddrList[1] = 32'h14;
    dKindList[0] = 0; dKindList[1] = 0; dCount = 2;
    pushExp(0, 0, 32'h10, 32'hC0DE0010);
    pushExp(0, 0, 32'h14, 32'hC0DE0014);
    dDriver();
    latency = 10;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("igntStrobe", {31'b0, ramREN}, 32'd1);
    checkOutput("igntAddr", ramaddr, 32'h20);
    checkOutput("igntBusyWait", {31'b0, iwait}, 32'd1);
    checkOutput("starveBeforeReset", {29'b0, dut.starveCnt_q}, 32'd2);
    RST = 1'b1;
    @(negedge CLK);
    checkIdleOutputs("midGrantReset");
    checkOutput("starveAfterReset", {29'b0, dut.starveCnt_q}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0; iREN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("scoreboardEmpty", sbQ.size(), 32'd0);
  endtask

  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The parameter STARVE_MAX SHALL default to 4 and set the number of consecutive dcache words granted while icache waits before icache is forced.
REQ-002 CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 RST  in  1  reset; one clock, synchronous, active-high.
REQ-004 iREN  in  1  icache read request.
REQ-005 iaddr  in  32  icache word address.
REQ-006 iload  out  32  instruction word returned, equal to ramload.
REQ-007 iwait  out  1  icache stall; low only in the cycle its access completes.
REQ-008 dREN, dWEN  in  1 each  dcache read and write requests.
REQ-009 daddr, dstore  in  32 each  dcache address and write data.
REQ-010 dload  out  32  data word returned, equal to ramload.
REQ-011 dwait  out  1  dcache stall; low only in the cycle its access completes.
REQ-012 ramREN, ramWEN  out  1 each  RAM read and write strobes.
REQ-013 ramaddr, ramstore  out  32 each  RAM address and write data.
REQ-014 ramload  in  32  RAM read data.
REQ-015 ramstate  in  ramstate_t  RAM status: FREE, BUSY, ACCESS or ERROR.

Function
REQ-016 The block SHALL use an FSM with states IDLE, IGNT and DGNT.
REQ-017 In IDLE, ramREN, ramWEN, ramaddr and ramstore SHALL be 0, and iwait and dwait SHALL be 1.
REQ-018 In IDLE with a dcache request (dREN|dWEN), the next state SHALL be DGNT if iREN=0 or starve_cnt<STARVE_MAX; otherwise the next state SHALL be IGNT.
REQ-019 In IDLE with only iREN asserted, the next state SHALL be IGNT; with no request, the state SHALL stay IDLE.
REQ-020 In IGNT: ramREN=iREN, ramWEN=0, ramaddr=iaddr, iwait=!(ramstate==ACCESS), dwait=1.
REQ-021 In DGNT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&!dWEN (write wins if both are asserted), dwait=!(ramstate==ACCESS), iwait=1.
REQ-022 In a grant state, ramstate==ACCESS SHALL complete one word, and the next state SHALL be IDLE.
REQ-023 In a grant state, ramstate==ERROR SHALL keep wait high and return the FSM to IDLE; the requester retries by holding its request.
REQ-024 If the granted requester drops its request before ACCESS, the strobes SHALL drop the same cycle and the next state SHALL be IDLE.
REQ-025 Latency: request seen in IDLE at cycle 0, grant at cycle 1, earliest wait low at cycle 1, back in IDLE at cycle 2; peak throughput SHALL be one word per 2 cycles.
REQ-026 starve_cnt (3 bits) SHALL increment on each dcache completion while iREN=1, and SHALL saturate at STARVE_MAX.
REQ-027 starve_cnt SHALL clear on icache completion, or in any cycle where iREN=0.
REQ-028 iload and dload SHALL be ramload combinationally in all states; consumers qualify them with their own wait signal.
REQ-029 iwait and dwait SHALL never both be low in the same cycle.

Reset
REQ-030 RST high at a clock edge SHALL force state=IDLE and starve_cnt=0, including mid-grant, which abandons the in-flight word.
REQ-031 During and after reset until the next grant, the outputs SHALL hold their IDLE values: strobes 0, address/store 0, iwait=dwait=1.

Structure
REQ-032 ramstate_t, word_t and the arbiter state enum SHALL live in cpu_types_pkg; STARVE_MAX SHALL remain a module parameter.
REQ-033 The block SHALL be a single module with no sub-modules; it SHALL be instantiated in memory_control between the caches and the RAM.

Verification
REQ-034 iREN=1, iaddr=0x40, RAM ACCESS one cycle after grant, ramload=0xDEADBEEF -> ramaddr=0x40 during IGNT, iload=0xDEADBEEF, iwait=0 for exactly one cycle.
REQ-035 dWEN=1 and iREN=1 simultaneously, daddr=0x3100, dstore=0x5 -> DGNT first with ramWEN=1 and ramstore=0x5; IGNT follows after completion.
REQ-036 iREN=1 held with dREN=1 held continuously, STARVE_MAX=4 -> exactly 4 dcache completions, then one icache completion, then dcache resumes.
REQ-037 ramstate=BUSY for 5 cycles, then ACCESS during DGNT -> dwait=1 for 5 cycles, dwait=0 on cycle 6, and the FSM is in IDLE the next cycle.
REQ-038 RST asserted in the middle of IGNT with ramstate=BUSY -> the next cycle is IDLE with ramREN=0 and iwait=1, and starve_cnt=0.
REQ-039 ramstate=ERROR during DGNT with dREN held -> dwait stays 1, the FSM returns to IDLE, re-grants DGNT, and completes on a later ACCESS.
